ra_writer: RTL and testbench
============================

RA_WRITER -- requirements
Module: ra_writer

Interface
REQ-001 Parameter: ZCLEAR, 1'b1, value placed in control-word bit30 of every entry.
REQ-002 clock  in  1  system clock; all state changes on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 ra_build_trig  in  1  single-cycle start pulse.
REQ-005 FPU_PARAM_CFG  in  32  bit21 = region format v2 (six-word entry with punch-through pointer); clear = v1 (five-word entry).
REQ-006 TA_ALLOC_CTRL  in  32  OPB size codes: [1:0] O, [5:4] OM, [9:8] T, [13:12] TM, [17:16] PT.
REQ-007 TA_GLOB_TILE_CLIP  in  32  [5:0] last tile X (xmax), [19:16] last tile Y (ymax).
REQ-008 REGION_BASE  in  32  VRAM byte address of the first region entry; bits [22:0] used.
REQ-009 OL_BASE  in  32  object-list byte offset written into pointers; bits [23:0] used.
REQ-010 ra_vram_wr  out  1  write strobe.
REQ-011 ra_vram_addr  out  24  write byte address.
REQ-012 ra_vram_dout  out  32  write data.
REQ-013 ra_vram_wait  in  1  memory stall; a word is accepted only in a cycle where ra_vram_wr=1 and ra_vram_wait=0.
REQ-014 ra_busy  out  1  high from the cycle after an accepted trigger until done.
REQ-015 ra_done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 States SHALL be IDLE, SETUP, WR_CTRL, WR_O, WR_OM, WR_T, WR_TM, WR_PT, NEXT, DONE.
REQ-017 IDLE: on ra_build_trig, latch config inputs, go to SETUP; in all other states ra_build_trig SHALL be ignored.
REQ-018 OPB byte size per list SHALL be 0 for code 0, else 16<<code (32/64/128 bytes).
REQ-019 SETUP (1 cycle): ntiles=(xmax+1)*(ymax+1); running pointers start at O=OL_BASE, OM=O+ntiles*szO, T=OM+ntiles*szOM, TM=T+ntiles*szT, PT=TM+ntiles*szTM, 24-bit wrap arithmetic; tile x=y=0; addr=REGION_BASE[22:0].
REQ-020 Tile order: X inner (0..xmax), Y outer (0..ymax).
REQ-021 WR_CTRL data: bit31=last (x==xmax and y==ymax), bit30=ZCLEAR, bit28=0, [13:8]=y, [7:2]=x, all other bits 0.
REQ-022 WR_O..WR_PT data: {8'h00, running pointer} if size code nonzero; 32'h80000000 if code 0.
REQ-023 WR_PT SHALL be visited only when FPU_PARAM_CFG[21] latched set; v1 goes WR_TM -> NEXT.
REQ-024 Each WR_* state SHALL hold ra_vram_wr=1 with stable addr/data until accepted; on acceptance addr+=4 and state advances.
REQ-025 NEXT (1 cycle, no write): each running pointer += its OPB size; if last tile -> DONE, else advance x (wrap to 0, y+1) -> WR_CTRL.
REQ-026 DONE: ra_done=1 for one cycle, ra_busy=0, -> IDLE.
REQ-027 Total words written SHALL be ntiles*5 (v1) or ntiles*6 (v2), contiguous from REGION_BASE.
REQ-028 ra_vram_wait asserted any number of cycles SHALL only stall, never skip or duplicate a word.
REQ-029 Config input changes after trigger SHALL not affect the build in progress.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, ra_vram_wr=0, ra_busy=0, ra_done=0, ra_vram_addr=0, ra_vram_dout=0, counters and pointers 0.
REQ-031 Reset asserted mid-build SHALL abandon the build; no write strobe after reset asserts; next trigger starts a fresh build.

Verification
REQ-032 xmax=0,ymax=0, v1, all codes=1, REGION_BASE=0x1000, OL_BASE=0 -> 5 writes at 0x1000..0x1010: 0xC0000000,0x0,0x20,0x40,0x60; ra_done once.
REQ-033 xmax=1,ymax=1, v2, codes O=2, others 0, OL_BASE=0x100 -> 24 writes; O pointers 0x100,0x140,0x180,0x1C0; other pointers 0x80000000; control words 0x40000000,0x40000004,0x40000100,0xC0000104.
REQ-034 Same as REQ-032 with ra_vram_wait high 3 cycles on every word -> identical data/addresses, each held 4 cycles.
REQ-035 Trigger pulsed again during build -> ignored; exactly one ra_done; word count unchanged.
REQ-036 reset_n low after 7th word accepted -> ra_vram_wr low immediately; retrigger rewrites from REGION_BASE with correct first control word.
REQ-037 xmax=39,ymax=14, v2, all codes=3 -> 3600 words; final control 0xC0000E9C; final PT pointer=OL_BASE+4*600*128+599*128.

Source files
------------

// File: rtl/ra_writer_if.sv
`default_nettype none
// ============================================================================
// ra_writer_if : VRAM write port between the region-array writer and memory
// Revision     : 1.0
// ============================================================================
interface ra_writer_if;
    logic        ra_vram_wr;
    logic [23:0] ra_vram_addr;
    logic [31:0] ra_vram_dout;
    logic        ra_vram_wait;

    modport master (
        output ra_vram_wr,
        output ra_vram_addr,
        output ra_vram_dout,
        input  ra_vram_wait
    );

    modport slave (
        input  ra_vram_wr,
        input  ra_vram_addr,
        input  ra_vram_dout,
        output ra_vram_wait
    );
endinterface
`default_nettype wire

// File: rtl/ra_writer.sv
`default_nettype none
// ============================================================================
// ra_writer : builds the tile region array in VRAM (5 or 6 words per tile)
// Revision  : 1.0
// ============================================================================
module ra_writer #(
    parameter logic ZCLEAR = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ra_build_trig,
    input  logic [31:0] FPU_PARAM_CFG,
    input  logic [31:0] TA_ALLOC_CTRL,
    input  logic [31:0] TA_GLOB_TILE_CLIP,
    input  logic [31:0] REGION_BASE,
    input  logic [31:0] OL_BASE,
    output logic        ra_busy,
    output logic        ra_done,
    ra_writer_if.master vram
);
    typedef enum logic [3:0] {
        IDLE, SETUP, WR_CTRL, WR_O, WR_OM, WR_T, WR_TM, WR_PT, NEXT, DONE
    } state_t;

    state_t           state_q, state_d;
    logic             v2_q, v2_d;
    logic [4:0][1:0]  code_q, code_d;
    logic [5:0]       xmax_q, xmax_d, x_q, x_d;
    logic [3:0]       ymax_q, ymax_d, y_q, y_d;
    logic [22:0]      rbase_q, rbase_d;
    logic [23:0]      olbase_q, olbase_d;
    logic [23:0]      addr_q, addr_d;
    logic [4:0][23:0] ptr_q, ptr_d;

    function automatic logic [23:0] opb_bytes(input logic [1:0] code);
        return (code == 2'd0) ? 24'd0 : (24'd16 << code);
    endfunction

    logic        last_tile;
    logic [23:0] ntiles;
    logic [23:0] base_om, base_t, base_tm, base_pt;
    logic        wr;
    logic [31:0] dout;
    logic [2:0]  lidx;
    logic        ptr_word;
    state_t      after_wr;

    assign last_tile = (x_q == xmax_q) && (y_q == ymax_q);
    assign ntiles    = ({18'd0, xmax_q} + 24'd1) * ({20'd0, ymax_q} + 24'd1);
    // Lists are packed back to back, each sized for every tile.
    assign base_om   = olbase_q + ntiles * opb_bytes(code_q[0]);
    assign base_t    = base_om  + ntiles * opb_bytes(code_q[1]);
    assign base_tm   = base_t   + ntiles * opb_bytes(code_q[2]);
    assign base_pt   = base_tm  + ntiles * opb_bytes(code_q[3]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            v2_q     <= 1'b0;
            code_q   <= '0;
            xmax_q   <= '0;
            ymax_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rbase_q  <= '0;
            olbase_q <= '0;
            addr_q   <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            v2_q     <= v2_d;
            code_q   <= code_d;
            xmax_q   <= xmax_d;
            ymax_q   <= ymax_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rbase_q  <= rbase_d;
            olbase_q <= olbase_d;
            addr_q   <= addr_d;
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        v2_d     = v2_q;
        code_d   = code_q;
        xmax_d   = xmax_q;
        ymax_d   = ymax_q;
        x_d      = x_q;
        y_d      = y_q;
        rbase_d  = rbase_q;
        olbase_d = olbase_q;
        addr_d   = addr_q;
        ptr_d    = ptr_q;
        wr       = 1'b0;
        dout     = '0;
        lidx     = 3'd0;
        ptr_word = 1'b0;
        after_wr = state_q;

        case (state_q)
            IDLE: begin
                if (ra_build_trig) begin
                    v2_d     = FPU_PARAM_CFG[21];
                    code_d   = {TA_ALLOC_CTRL[17:16], TA_ALLOC_CTRL[13:12], TA_ALLOC_CTRL[9:8],
                                TA_ALLOC_CTRL[5:4], TA_ALLOC_CTRL[1:0]};
                    xmax_d   = TA_GLOB_TILE_CLIP[5:0];
                    ymax_d   = TA_GLOB_TILE_CLIP[19:16];
                    rbase_d  = REGION_BASE[22:0];
                    olbase_d = OL_BASE[23:0];
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                ptr_d   = {base_pt, base_tm, base_t, base_om, olbase_q};
                x_d     = '0;
                y_d     = '0;
                addr_d  = {1'b0, rbase_q};
                state_d = WR_CTRL;
            end
            WR_CTRL: begin
                wr       = 1'b1;
                dout     = {last_tile, ZCLEAR, 16'd0, 2'd0, y_q, x_q, 2'd0};
                after_wr = WR_O;
            end
            WR_O:  begin ptr_word = 1'b1; lidx = 3'd0; after_wr = WR_OM; end
            WR_OM: begin ptr_word = 1'b1; lidx = 3'd1; after_wr = WR_T;  end
            WR_T:  begin ptr_word = 1'b1; lidx = 3'd2; after_wr = WR_TM; end
            WR_TM: begin ptr_word = 1'b1; lidx = 3'd3; after_wr = v2_q ? WR_PT : NEXT; end
            WR_PT: begin ptr_word = 1'b1; lidx = 3'd4; after_wr = NEXT;  end
            NEXT: begin
                for (int i = 0; i < 5; i++) begin
                    ptr_d[i] = ptr_q[i] + opb_bytes(code_q[i]);
                end
                if (last_tile) begin
                    state_d = DONE;
                end else begin
                    if (x_q == xmax_q) begin
                        x_d = '0;
                        y_d = y_q + 4'd1;
                    end else begin
                        x_d = x_q + 6'd1;
                    end
                    state_d = WR_CTRL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Unallocated lists get the empty-pointer marker instead of an address.
        if (ptr_word) begin
            wr   = 1'b1;
            dout = (code_q[lidx] == 2'd0) ? 32'h8000_0000 : {8'h00, ptr_q[lidx]};
        end

        if (wr && !vram.ra_vram_wait) begin
            addr_d  = addr_q + 24'd4;
            state_d = after_wr;
        end
    end

    assign vram.ra_vram_wr   = wr;
    assign vram.ra_vram_addr = addr_q;
    assign vram.ra_vram_dout = dout;
    assign ra_busy           = (state_q != IDLE) && (state_q != DONE);
    assign ra_done           = (state_q == DONE);

    logic unused_cfg;
    assign unused_cfg = ^{FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0],
                          TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10],
                          TA_ALLOC_CTRL[7:6], TA_ALLOC_CTRL[3:2],
                          TA_GLOB_TILE_CLIP[31:20], TA_GLOB_TILE_CLIP[15:6],
                          REGION_BASE[31:23], OL_BASE[31:24]};
endmodule
`default_nettype wire

// File: tb/tb_ra_writer.sv
`default_nettype none
// ============================================================================
// tb_ra_writer : region-array builds compared word by word with a tile model
// Revision     : 1.0
// ============================================================================
module tb_ra_writer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        ra_build_trig;
    logic [31:0] FPU_PARAM_CFG, TA_ALLOC_CTRL, TA_GLOB_TILE_CLIP, REGION_BASE, OL_BASE;
    logic        ra_busy, ra_done;

    ra_writer_if vif();

    ra_writer #(.ZCLEAR(1'b1)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ra_build_trig     (ra_build_trig),
        .FPU_PARAM_CFG     (FPU_PARAM_CFG),
        .TA_ALLOC_CTRL     (TA_ALLOC_CTRL),
        .TA_GLOB_TILE_CLIP (TA_GLOB_TILE_CLIP),
        .REGION_BASE       (REGION_BASE),
        .OL_BASE           (OL_BASE),
        .ra_busy           (ra_busy),
        .ra_done           (ra_done),
        .vram              (vif)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          wait_mode = 0;
    logic [55:0] exp_q[$];
    logic [55:0] log_q[$];

    logic [31:0] r032_data [5] = '{32'hC000_0000, 32'h0, 32'h20, 32'h40, 32'h60};
    logic [31:0] r033_ctrl [4] = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0100, 32'hC000_0104};
    logic [31:0] r033_optr [4] = '{32'h100, 32'h140, 32'h180, 32'h1C0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [23:0] sz_of(input logic [1:0] c);
        case (c)
            2'd1:    return 24'd32;
            2'd2:    return 24'd64;
            2'd3:    return 24'd128;
            default: return 24'd0;
        endcase
    endfunction

    // Each pointer is computed directly from the tile's linear index.
    task automatic build_model(input logic v2, input logic [9:0] codes, input int xmax, input int ymax,
                               input logic [31:0] rbase, input logic [31:0] olbase);
        int          nt;
        int          nl;
        logic [23:0] start [5];
        logic [23:0] sz [5];
        logic [23:0] a;
        logic [31:0] d;
        nt = (xmax + 1) * (ymax + 1);
        nl = v2 ? 5 : 4;
        for (int l = 0; l < 5; l++) sz[l] = sz_of(codes[2*l +: 2]);
        start[0] = olbase[23:0];
        for (int l = 1; l < 5; l++) start[l] = start[l-1] + 24'(nt) * sz[l-1];
        a = {1'b0, rbase[22:0]};
        for (int y = 0; y <= ymax; y++) begin
            for (int x = 0; x <= xmax; x++) begin
                int t;
                t = y * (xmax + 1) + x;
                d = 32'h4000_0000 | (((x == xmax) && (y == ymax)) ? 32'h8000_0000 : 32'h0)
                    | 32'(y << 8) | 32'(x << 2);
                exp_q.push_back({a, d});
                a = a + 24'd4;
                for (int l = 0; l < nl; l++) begin
                    d = (sz[l] == 24'd0) ? 32'h8000_0000 : {8'h00, start[l] + 24'(t) * sz[l]};
                    exp_q.push_back({a, d});
                    a = a + 24'd4;
                end
            end
        end
    endtask

    task automatic start_build(input logic v2, input logic [9:0] codes, input int xmax, input int ymax,
                               input logic [31:0] rbase, input logic [31:0] olbase, input int mode);
        exp_q.delete();
        log_q.delete();
        done_cnt  = 0;
        wait_mode = mode;
        build_model(v2, codes, xmax, ymax, rbase, olbase);
        @(negedge clock);
        FPU_PARAM_CFG = $urandom;
        FPU_PARAM_CFG[21] = v2;
        TA_ALLOC_CTRL = $urandom;
        TA_ALLOC_CTRL[1:0]   = codes[1:0];
        TA_ALLOC_CTRL[5:4]   = codes[3:2];
        TA_ALLOC_CTRL[9:8]   = codes[5:4];
        TA_ALLOC_CTRL[13:12] = codes[7:6];
        TA_ALLOC_CTRL[17:16] = codes[9:8];
        TA_GLOB_TILE_CLIP = $urandom;
        TA_GLOB_TILE_CLIP[5:0]   = 6'(xmax);
        TA_GLOB_TILE_CLIP[19:16] = 4'(ymax);
        REGION_BASE = rbase;
        OL_BASE     = olbase;
        ra_build_trig = 1'b1;
        @(negedge clock);
        ra_build_trig = 1'b0;
        FPU_PARAM_CFG     = $urandom;
        TA_ALLOC_CTRL     = $urandom;
        TA_GLOB_TILE_CLIP = $urandom;
        REGION_BASE       = $urandom;
        OL_BASE           = $urandom;
    endtask

    task automatic run_build(input logic v2, input logic [9:0] codes, input int xmax, input int ymax,
                             input logic [31:0] rbase, input logic [31:0] olbase, input int mode,
                             input bit retrig);
        int n;
        int budget;
        start_build(v2, codes, xmax, ymax, rbase, olbase, mode);
        n = exp_q.size();
        budget = n * 6 + 100;
        for (int c = 0; c < budget && done_cnt == 0; c++) begin
            @(negedge clock);
            #1;
            ra_build_trig = (retrig && done_cnt == 0 && (c % 7) == 3);
        end
        ra_build_trig = 1'b0;
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (6) @(negedge clock);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("word_count", 64'(log_q.size()), 64'(n));
    endtask

    // Monitor: decides the wait for the coming edge, then records any accepted word.
    initial begin
        logic [55:0] cur;
        logic [55:0] prev;
        int          pres;
        bit          stalled;
        logic        w;
        pres = 0;
        stalled = 0;
        prev = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pres = 0;
                stalled = 0;
                continue;
            end
            cur = {vif.ra_vram_addr, vif.ra_vram_dout};
            if (stalled) begin
                chk("hold_wr", 64'(vif.ra_vram_wr), 64'd1);
                chk("hold_word", 64'(cur), 64'(prev));
            end
            if (vif.ra_vram_wr) begin
                pres++;
                chk("busy_wr", 64'(ra_busy), 64'd1);
                case (wait_mode)
                    0:       w = 1'b0;
                    1:       w = ($urandom_range(0, 2) == 0);
                    default: w = (pres < 4);
                endcase
                vif.ra_vram_wait = w;
                if (!w) begin
                    log_q.push_back(cur);
                    if (wait_mode == 2) chk("hold_len", 64'(pres), 64'd4);
                    if (exp_q.size() == 0) chk("extra_word", 64'(cur), 64'd0);
                    else chk("word", 64'(cur), 64'(exp_q.pop_front()));
                    pres = 0;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = cur;
                end
            end else begin
                vif.ra_vram_wait = (wait_mode == 1) ? ($urandom_range(0, 1) == 0) : 1'b0;
                pres = 0;
                stalled = 0;
            end
            if (ra_done) begin
                done_cnt++;
                chk("busy_at_done", 64'(ra_busy), 64'd0);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ra_build_trig = 1'b0;
        vif.ra_vram_wait = 1'b0;
        FPU_PARAM_CFG = '0;
        TA_ALLOC_CTRL = '0;
        TA_GLOB_TILE_CLIP = '0;
        REGION_BASE = '0;
        OL_BASE = '0;
        repeat (3) @(negedge clock);
        chk("rst_wr", 64'(vif.ra_vram_wr), 64'd0);
        chk("rst_addr", 64'(vif.ra_vram_addr), 64'd0);
        chk("rst_dout", 64'(vif.ra_vram_dout), 64'd0);
        chk("rst_busy", 64'(ra_busy), 64'd0);
        chk("rst_done", 64'(ra_done), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // single tile, v1, all codes 1
        run_build(1'b0, 10'b01_01_01_01_01, 0, 0, 32'h0000_1000, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++)
            chk("r032_word", 64'(log_q[i]), 64'({24'h001000 + 24'(4 * i), r032_data[i]}));

        // 2x2 tiles, v2, only O allocated
        run_build(1'b1, 10'b00_00_00_00_10, 1, 1, 32'h0000_2000, 32'h0000_0100, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("r033_ctrl", 64'(log_q[6*i][31:0]), 64'(r033_ctrl[i]));
            chk("r033_optr", 64'(log_q[6*i+1][31:0]), 64'(r033_optr[i]));
            chk("r033_pt", 64'(log_q[6*i+5][31:0]), 64'h8000_0000);
        end

        // same as the single-tile case with every word stalled 3 cycles
        run_build(1'b0, 10'b01_01_01_01_01, 0, 0, 32'h0000_1000, 32'h0, 2, 0);
        for (int i = 0; i < 5; i++)
            chk("r034_word", 64'(log_q[i]), 64'({24'h001000 + 24'(4 * i), r032_data[i]}));

        // retrigger pulses during a build are ignored
        run_build(1'b0, 10'(($urandom)), 2, 1, $urandom, $urandom, 1, 1);

        // reset after the 7th accepted word abandons the build
        begin
            bit seen;
            seen = 0;
            start_build(1'b0, 10'b01_01_01_01_01, 1, 0, 32'h0000_1000, 32'h0, 0);
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clock);
                #1;
                seen = (log_q.size() >= 7);
            end
            if (!seen) chk("r036_timeout", 64'd0, 64'd1);
            @(posedge clock);
            #1;
            reset_n = 1'b0;
            #1;
            chk("r036_wr", 64'(vif.ra_vram_wr), 64'd0);
            chk("r036_addr", 64'(vif.ra_vram_addr), 64'd0);
            chk("r036_busy", 64'(ra_busy), 64'd0);
            chk("r036_done", 64'(ra_done), 64'd0);
            repeat (3) begin
                @(negedge clock);
                chk("r036_wr_held", 64'(vif.ra_vram_wr), 64'd0);
            end
            chk("r036_no_done", 64'(done_cnt), 64'd0);
            reset_n = 1'b1;
            @(negedge clock);
            run_build(1'b0, 10'b01_01_01_01_01, 1, 0, 32'h0000_1000, 32'h0, 0, 0);
            chk("r036_first", 64'(log_q[0]), 64'({24'h001000, 32'h4000_0000}));
        end

        // full-size screen, v2, all lists 128 bytes
        run_build(1'b1, 10'b11_11_11_11_11, 39, 14, 32'h0004_0000, 32'h0000_1000, 1, 0);
        chk("r037_last_ctrl", 64'(log_q[3594][31:0]), 64'hC000_0E9C);
        chk("r037_last_pt", 64'(log_q[3599][31:0]),
            64'(32'h1000 + 32'(4 * 600 * 128) + 32'(599 * 128)));

        for (int k = 0; k < 6; k++) begin
            run_build(1'($urandom), 10'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                      $urandom, $urandom, int'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
